bus_arbiter: RTL and testbench

Round-robin bus arbiter and transfer sequencer that shares the single slave control path between N masters. It grants one master at a time, issues the slave start pulse, waits for the slave's ready and response, and acts on OKAY/RETRY/SPLIT/ERROR. Split masters are masked until the slave releases them. It sits between the master request lines and the slave control path.

---
 rtl/bus_arbiter_pkg.sv | 23 ++
 rtl/bus_arbiter_if.sv | 40 ++++
 rtl/bus_arbiter_rr_picker.sv | 42 ++++
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_bus_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice: the slave response codes, the
// arbiter FSM state encoding and a width helper for index and counter vectors.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespRetry = 2'b01,
    RespSplit = 2'b10,
    RespError = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAddr = 2'b01,
    StData = 2'b10
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and slave control bundle between the masters, the arbiter and
// the slave.
//   req, split_release       : per-master request level, slave split unmask pulse
//   slv_rdy, slv_resp        : slave ready and response code
//   grant, master_id         : one-hot grant and its index
//   slv_start                : one-cycle start pulse to the slave
//   done, err                : per-master completion / failure pulses
//   split_mask               : masters parked by a SPLIT response
//   busy                     : arbiter is in a transfer
// Modport master is the arbiter's view; modport slave is the surrounding side.
interface bus_arbiter_if #(
  parameter int unsigned N_MASTERS = 2
);
  import bus_arbiter_pkg::*;

  localparam int unsigned IdW = id_width(N_MASTERS);

  logic [N_MASTERS-1:0] req;
  logic                 slv_rdy;
  logic [1:0]           slv_resp;
  logic [N_MASTERS-1:0] split_release;
  logic [N_MASTERS-1:0] grant;
  logic [IdW-1:0]       master_id;
  logic                 slv_start;
  logic [N_MASTERS-1:0] done;
  logic [N_MASTERS-1:0] err;
  logic [N_MASTERS-1:0] split_mask;
  logic                 busy;

  modport master (
    input  req, slv_rdy, slv_resp, split_release,
    output grant, master_id, slv_start, done, err, split_mask, busy
  );

  modport slave (
    output req, slv_rdy, slv_resp, split_release,
    input  grant, master_id, slv_start, done, err, split_mask, busy
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: returns the first set bit of eligible at
// or after ptr, wrapping around.
//   eligible : candidate vector
//   ptr      : search start index (must be < N_MASTERS)
//   onehot   : selected master, one-hot
//   idx      : selected master index
//   valid    : any candidate found
module bus_arbiter_rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  localparam int unsigned IdW = id_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [IdW-1:0]       ptr,
  output logic [N_MASTERS-1:0] onehot,
  output logic [IdW-1:0]       idx,
  output logic                 valid
);

  logic [IdW:0]   sum;
  logic [IdW-1:0] jw;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    sum    = '0;
    jw     = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      // ptr + i is below 2*N_MASTERS, so one conditional subtract is the modulo.
      sum = {1'b0, ptr} + (IdW + 1)'(i);
      jw  = (sum >= (IdW + 1)'(N_MASTERS)) ? IdW'(sum - (IdW + 1)'(N_MASTERS)) : IdW'(sum);
      if (!valid && eligible[jw]) begin
        valid      = 1'b1;
        idx        = jw;
        onehot[jw] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and transfer sequencer sharing one slave control path
// between N_MASTERS masters. IDLE picks a master, ADDR issues the slave start
// pulse, DATA waits for slave ready and acts on the response. All outputs are
// registered.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bus_arbiter_if master modport (requests, slave handshake, grants)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  localparam int unsigned IdW    = id_width(N_MASTERS);
  localparam int unsigned WaitW  = id_width(TIMEOUT);
  localparam int unsigned RetryW = id_width(MAX_RETRY);

  state_e               state_q;
  logic [N_MASTERS-1:0] grant_q, done_q, err_q, split_mask_q;
  logic [IdW-1:0]       id_q, rr_q;
  logic                 start_q, busy_q;
  logic [WaitW-1:0]     wait_q;
  logic [RetryW-1:0]    retry_q;

  logic [N_MASTERS-1:0] eligible, pick_onehot, split_set;
  logic [IdW-1:0]       pick_idx;
  logic                 pick_valid;

  function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
    return (id == IdW'(N_MASTERS - 1)) ? '0 : id + 1'b1;
  endfunction

  assign eligible  = bus.req & ~split_mask_q;
  assign split_set = (state_q == StData && bus.slv_rdy && resp_e'(bus.slv_resp) == RespSplit)
                     ? grant_q : '0;

  bus_arbiter_rr_picker #(
    .N_MASTERS(N_MASTERS)
  ) u_picker (
    .eligible(eligible),
    .ptr     (rr_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      id_q         <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      split_mask_q <= '0;
      rr_q         <= '0;
      wait_q       <= '0;
      retry_q      <= '0;
    end else begin
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      // Release is applied after set so a same-cycle release wins.
      split_mask_q <= (split_mask_q | split_set) & ~bus.split_release;

      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StAddr;
            grant_q <= pick_onehot;
            id_q    <= pick_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StAddr: begin
          state_q <= StData;
          wait_q  <= '0;
        end
        StData: begin
          if (bus.slv_rdy) begin
            state_q <= StIdle;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            unique case (resp_e'(bus.slv_resp))
              RespOkay: begin
                done_q  <= grant_q;
                retry_q <= '0;
                rr_q    <= next_id(id_q);
              end
              RespRetry: begin
                if (retry_q == RetryW'(MAX_RETRY - 1)) begin
                  err_q   <= grant_q;
                  retry_q <= '0;
                  rr_q    <= next_id(id_q);
                end else begin
                  // Pointer left alone so the same master re-wins if still requesting.
                  retry_q <= retry_q + 1'b1;
                end
              end
              RespSplit: begin
                retry_q <= '0;
                rr_q    <= next_id(id_q);
              end
              RespError: begin
                err_q   <= grant_q;
                retry_q <= '0;
                rr_q    <= next_id(id_q);
              end
            endcase
          end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
            state_q <= StIdle;
            grant_q <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= grant_q;
            retry_q <= '0;
            rr_q    <= next_id(id_q);
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.master_id  = id_q;
  assign bus.slv_start  = start_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.split_mask = split_mask_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters, TIMEOUT=64, MAX_RETRY=3.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned N = 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  bus_arbiter_if #(.N_MASTERS(N)) bus ();

  bus_arbiter #(
    .N_MASTERS(N),
    .TIMEOUT  (64),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Window right after a grant: ADDR cycle with start pulse.
  task automatic check_grant(input string tag, input logic [7:0] g, input logic [7:0] id);
    check({tag, ".grant"}, 8'(bus.grant), g);
    check({tag, ".id"}, 8'(bus.master_id), id);
    check({tag, ".start"}, 8'(bus.slv_start), 8'h1);
    check({tag, ".busy"}, 8'(bus.busy), 8'h1);
    check({tag, ".done"}, 8'(bus.done), 8'h0);
    check({tag, ".err"}, 8'(bus.err), 8'h0);
  endtask

  // Window after the transfer ends: back in IDLE with registered pulses.
  task automatic check_end(input string tag, input logic [7:0] d, input logic [7:0] e);
    check({tag, ".done"}, 8'(bus.done), d);
    check({tag, ".err"}, 8'(bus.err), e);
    check({tag, ".grant"}, 8'(bus.grant), 8'h0);
    check({tag, ".busy"}, 8'(bus.busy), 8'h0);
  endtask

  // Called in the ADDR window; n_wait DATA cycles without ready, then one with ready.
  task automatic xfer(input string tag, input int n_wait, input logic [1:0] resp,
                      input logic [7:0] g);
    bus.slv_rdy  = 1'b0;
    bus.slv_resp = resp;
    step();
    repeat (n_wait) step();
    check({tag, ".hold"}, 8'(bus.grant), g);
    check({tag, ".nostart"}, 8'(bus.slv_start), 8'h0);
    bus.slv_rdy = 1'b1;
    step();
    bus.slv_rdy = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.req           = '0;
    bus.slv_rdy       = 1'b0;
    bus.slv_resp      = RespOkay;
    bus.split_release = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.grant", 8'(bus.grant), 8'h0);
    check("rst.id", 8'(bus.master_id), 8'h0);
    check("rst.start", 8'(bus.slv_start), 8'h0);
    check("rst.done", 8'(bus.done), 8'h0);
    check("rst.err", 8'(bus.err), 8'h0);
    check("rst.mask", 8'(bus.split_mask), 8'h0);
    check("rst.busy", 8'(bus.busy), 8'h0);
    rst = 1'b0;

    // Both request, OKAY after two waits each: master 0 then master 1.
    bus.req = 2'b11;
    step();
    check_grant("t1.g0", 8'h1, 8'h0);
    xfer("t1.x0", 2, RespOkay, 8'h1);
    check_end("t1.e0", 8'h1, 8'h0);
    step();
    check_grant("t1.g1", 8'h2, 8'h1);
    xfer("t1.x1", 2, RespOkay, 8'h2);
    check_end("t1.e1", 8'h2, 8'h0);

    // Master 0: RETRY, RETRY, OKAY; re-granted each time before master 1.
    step();
    check_grant("t2.g0a", 8'h1, 8'h0);
    xfer("t2.x0a", 0, RespRetry, 8'h1);
    check_end("t2.e0a", 8'h0, 8'h0);
    step();
    check_grant("t2.g0b", 8'h1, 8'h0);
    xfer("t2.x0b", 0, RespRetry, 8'h1);
    check_end("t2.e0b", 8'h0, 8'h0);
    step();
    check_grant("t2.g0c", 8'h1, 8'h0);
    xfer("t2.x0c", 0, RespOkay, 8'h1);
    check_end("t2.e0c", 8'h1, 8'h0);
    step();
    check_grant("t2.g1", 8'h2, 8'h1);

    // Master 1 is split and skipped until released.
    xfer("t3.x1", 1, RespSplit, 8'h2);
    check_end("t3.e1", 8'h0, 8'h0);
    check("t3.mask_set", 8'(bus.split_mask), 8'h2);
    step();
    check_grant("t3.g0a", 8'h1, 8'h0);
    xfer("t3.x0a", 0, RespOkay, 8'h1);
    check_end("t3.e0a", 8'h1, 8'h0);
    step();
    check_grant("t3.g0b", 8'h1, 8'h0);
    check("t3.mask_held", 8'(bus.split_mask), 8'h2);
    bus.split_release = 2'b10;
    bus.slv_resp      = RespOkay;
    step();
    bus.split_release = '0;
    check("t3.mask_clr", 8'(bus.split_mask), 8'h0);
    bus.slv_rdy = 1'b1;
    step();
    bus.slv_rdy = 1'b0;
    check_end("t3.e0b", 8'h1, 8'h0);
    step();
    check_grant("t3.g1", 8'h2, 8'h1);

    // Slave never ready; request dropped mid-transfer does not abort it.
    bus.req = 2'b00;
    step();
    repeat (63) step();
    check("t4.hold_grant", 8'(bus.grant), 8'h2);
    check("t4.hold_busy", 8'(bus.busy), 8'h1);
    check("t4.hold_err", 8'(bus.err), 8'h0);
    step();
    check_end("t4.to", 8'h0, 8'h2);
    step();
    check_end("t4.quiet", 8'h0, 8'h0);
    check("t4.quiet_start", 8'(bus.slv_start), 8'h0);

    // Three RETRYs fail the transfer and pass the turn to master 1.
    bus.req = 2'b11;
    step();
    check_grant("t5.g0a", 8'h1, 8'h0);
    xfer("t5.x0a", 1, RespRetry, 8'h1);
    check_end("t5.e0a", 8'h0, 8'h0);
    step();
    check_grant("t5.g0b", 8'h1, 8'h0);
    xfer("t5.x0b", 0, RespRetry, 8'h1);
    check_end("t5.e0b", 8'h0, 8'h0);
    step();
    check_grant("t5.g0c", 8'h1, 8'h0);
    xfer("t5.x0c", 0, RespRetry, 8'h1);
    check_end("t5.e0c", 8'h0, 8'h1);
    step();
    check_grant("t5.g1", 8'h2, 8'h1);

    // Reset in the middle of DATA clears outputs without a clock edge.
    step();
    step();
    check("t6.pre_grant", 8'(bus.grant), 8'h2);
    rst = 1'b1;
    #1;
    check("t6.grant", 8'(bus.grant), 8'h0);
    check("t6.busy", 8'(bus.busy), 8'h0);
    check("t6.start", 8'(bus.slv_start), 8'h0);
    check("t6.id", 8'(bus.master_id), 8'h0);
    check("t6.done", 8'(bus.done), 8'h0);
    check("t6.err", 8'(bus.err), 8'h0);
    step();
    rst = 1'b0;
    step();
    check_grant("t6.g0", 8'h1, 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
